// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundle between the requesters / shared UART transmitter and the
//   round-robin transmit arbiter.
//
//   Parameters: N    - character width in bits
//               NREQ - number of requesters
//
//   Signals (direction as seen by the arbiter, modport slave):
//     req_valid   in   [NREQ]    per-requester transmit request
//     req_data    in   [NREQ*N]  flattened characters, requester i at [i*N +: N]
//     tx_busy     in   1         transmitter frame in progress
//     req_ready   out  [NREQ]    one-hot, one-cycle acceptance pulse
//     tx_data     out  [N]       character to the transmitter
//     up_data     out  1         one-cycle load strobe to the transmitter
//     grant_id    out  [clog2]   index of the last granted requester
//     busy        out  1         arbiter not idle
//     timeout_err out  1         one-cycle watchdog abort pulse
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
) ();
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic              tx_busy;
  logic [NREQ-1:0]   req_ready;
  logic [N-1:0]      tx_data;
  logic              up_data;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              timeout_err;

  // Requesters and transmitter side
  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, up_data, grant_id, busy, timeout_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, up_data, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter between NREQ requesters.
//   A request is granted only while the transmitter is idle; the grant issues
//   a one-cycle up_data strobe together with a one-hot req_ready pulse, then
//   the arbiter waits for the transmitter to go busy and back to idle before
//   granting again.
//
//   Parameters: N       - character width
//               NREQ    - number of requesters (2..16)
//               TIMEOUT - watchdog limit in cycles (only with the macro below)
//
//   Ports: clk  - clock, rising edge
//          rst  - asynchronous, active-high reset
//          bus  - uart_tx_arbiter_if.slave (requests, transmitter, status)
//
//   Optional feature: define UART_ARB_TIMEOUT_EN to enable a watchdog that
//   aborts the wait for the transmitter after TIMEOUT cycles and pulses
//   timeout_err. Without it timeout_err is tied low and the wait is unbounded.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be in 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     grant_id_q;
  logic [N-1:0]      tx_data_q;
  logic              up_data_q;
  logic [NREQ-1:0]   req_ready_q;
  logic              busy_q;

  logic [IW-1:0]     grant_d;
  logic              grant_found_d;
  logic [IW:0]       scan_idx_d;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     wd_cnt_q;
  logic              timeout_err_q;
`endif

  // Cyclic priority search starting at ptr_q. The index is kept one bit
  // wider so ptr+k can be wrapped by subtraction for non power-of-two NREQ.
  always_comb begin
    grant_d       = '0;
    grant_found_d = 1'b0;
    scan_idx_d    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx_d = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_idx_d >= (IW+1)'(NREQ)) begin
        scan_idx_d = scan_idx_d - (IW+1)'(NREQ);
      end
      if (!grant_found_d && bus.req_valid[scan_idx_d[IW-1:0]]) begin
        grant_d       = scan_idx_d[IW-1:0];
        grant_found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      up_data_q     <= 1'b0;
      req_ready_q   <= '0;
      busy_q        <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      up_data_q   <= 1'b0;
      req_ready_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (grant_found_d && !bus.tx_busy) begin
            state_q     <= LOAD;
            grant_id_q  <= grant_d;
            tx_data_q   <= bus.req_data[grant_d*N +: N];
            up_data_q   <= 1'b1;
            req_ready_q <= NREQ'(1) << grant_d;
            busy_q      <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= WAIT_BUSY;
          ptr_q   <= (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      // Watchdog overrides the normal wait transitions when it expires.
      if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
        if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          timeout_err_q <= 1'b1;
          wd_cnt_q      <= '0;
        end else begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.up_data   = up_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
